// File: rtl/count_sequence_checker.sv
// Receive-side monitor for a mod-2^WIDTH up-counter bus: locks onto a valid
// count, flags out-of-sequence samples, counts errors and reports wraps.
module count_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             exp_rst,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n, exp_val, expected_n;
  logic [RUN_W-1:0] run, run_n, run_inc;
  logic [ERR_W-1:0] err_cnt_n;
  logic             match, err_n, wrap_n;

  assign exp_val = exp_rst ? '0 : prev + ONE;
  assign match   = (q == exp_val);
  assign run_inc = run + RUN_ONE;
  assign locked  = (state == LOCK);

  always_comb begin
    state_n    = state;
    prev_n     = prev;
    run_n      = run;
    expected_n = expected;
    err_cnt_n  = err_cnt;
    err_n      = 1'b0;
    wrap_n     = 1'b0;
    if (en) begin
      prev_n     = q;
      expected_n = q + ONE;
      if (state == IDLE) begin
        run_n   = '0;
        state_n = ACQ;
      end else begin
        // A counter reset into 0 is a legal step but not a wrap.
        wrap_n = match && !exp_rst && (prev == MAX);
        if (state == LOCK) begin
          if (!match) begin
            err_n   = 1'b1;
            state_n = ACQ;
            run_n   = '0;
            if (err_cnt != '1) err_cnt_n = err_cnt + ERR_ONE;
          end
        end else if (match) begin
          if (run_inc == LOCK_RUN) begin
            state_n = LOCK;
            run_n   = '0;
          end else begin
            run_n = run_inc;
          end
        end else begin
          run_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prev     <= '0;
      run      <= '0;
      err      <= 1'b0;
      wrap     <= 1'b0;
      expected <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      prev     <= prev_n;
      run      <= run_n;
      err      <= err_n;
      wrap     <= wrap_n;
      expected <= expected_n;
      err_cnt  <= err_cnt_n;
    end
  end
endmodule

// File: tb/tb_count_sequence_checker.sv
// Scoreboard bench: the driver pushes model predictions per cycle, a monitor
// pops and compares them against two checkers (ERR_W=8 and ERR_W=2).
module tb_count_sequence_checker;
  localparam int W = 4;
  localparam int LC = 2;

  logic clk = 0;
  logic reset, en, exp_rst;
  logic [W-1:0] q;
  logic locked8, err8, wrap8, locked2, err2, wrap2;
  logic [W-1:0] exp8, exp2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  count_sequence_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) dut8 (
    .clk(clk), .reset(reset), .q(q), .en(en), .exp_rst(exp_rst),
    .locked(locked8), .err(err8), .wrap(wrap8), .expected(exp8), .err_cnt(cnt8));
  count_sequence_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .q(q), .en(en), .exp_rst(exp_rst),
    .locked(locked2), .err(err2), .wrap(wrap2), .expected(exp2), .err_cnt(cnt2));

  always #5 clk = ~clk;

  typedef struct {
    bit lk; bit er; bit wr; int ex; int errs;
  } resp_t;
  resp_t sb[$];

  int n_cmp = 0, n_bad = 0;

  // Reference model: "have we seen a first sample", last value, streak of
  // correct steps, lock flag and an unbounded error tally.
  bit m_first = 1, m_lk = 0;
  int m_prev = 0, m_streak = 0, m_errs = 0, m_ex = 0;

  task automatic step(input bit r, input bit e, input int qv, input bit er);
    resp_t o;
    int want;
    bit ok;
    @(negedge clk);
    reset = r; en = e; q = W'(qv); exp_rst = er;
    o.er = 0; o.wr = 0;
    if (r) begin
      m_first = 1; m_lk = 0; m_prev = 0; m_streak = 0; m_errs = 0; m_ex = 0;
    end else if (e) begin
      if (m_first) begin
        m_first = 0; m_streak = 0;
      end else begin
        want = er ? 0 : (m_prev + 1) % 16;
        ok = (qv == want);
        o.wr = ok && !er && m_prev == 15;
        if (m_lk) begin
          if (!ok) begin o.er = 1; m_errs++; m_lk = 0; m_streak = 0; end
        end else if (ok) begin
          m_streak++;
          if (m_streak == LC) begin m_lk = 1; m_streak = 0; end
        end else m_streak = 0;
      end
      m_prev = qv; m_ex = (qv + 1) % 16;
    end
    o.lk = m_lk; o.ex = m_ex; o.errs = m_errs;
    sb.push_back(o);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always begin
    resp_t r;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("locked8", int'(locked8), int'(r.lk));
      chk("err8", int'(err8), int'(r.er));
      chk("wrap8", int'(wrap8), int'(r.wr));
      chk("expected8", int'(exp8), r.ex);
      chk("err_cnt8", int'(cnt8), (r.errs > 255) ? 255 : r.errs);
      chk("locked2", int'(locked2), int'(r.lk));
      chk("err2", int'(err2), int'(r.er));
      chk("wrap2", int'(wrap2), int'(r.wr));
      chk("expected2", int'(exp2), r.ex);
      chk("err_cnt2", int'(cnt2), (r.errs > 3) ? 3 : r.errs);
    end
  end

  task automatic relock();
    for (int i = 0; i < LC + 1; i++) step(0, 1, (m_prev + 1) % 16, 0);
  endtask

  initial begin
    reset = 1; en = 0; q = 0; exp_rst = 0;
    step(1, 0, 0, 0);
    step(1, 1, 9, 0);
    // full count with wrap
    for (int i = 0; i < 18; i++) step(0, 1, i % 16, 0);
    // jump while locked, then relock
    for (int i = 2; i <= 5; i++) step(0, 1, i, 0);
    step(0, 1, 7, 0);
    step(0, 1, 8, 0);
    step(0, 1, 9, 0);
    // source counter reset accepted; plain jump to 0 is an error
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    relock();
    // exp_rst from 15 is not a wrap
    while (m_prev != 15) step(0, 1, (m_prev + 1) % 16, 0);
    step(0, 1, 0, 1);
    // stall while locked
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    relock();
    // idle cycles with noise on q
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(15), $urandom_range(1));
    step(0, 1, (m_prev + 1) % 16, 0);
    // reset wins over a mismatching sample
    step(1, 1, (m_prev + 3) % 16, 0);
    relock();
    // drive the counters past saturation
    for (int k = 0; k < 5; k++) begin
      step(0, 1, (m_prev + 2) % 16, 0);
      relock();
    end
    // random traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(99);
      if (sel < 2) step(1, $urandom_range(1), $urandom_range(15), 0);
      else if (sel < 20) step(0, 0, $urandom_range(15), $urandom_range(1));
      else if (sel < 75) step(0, 1, (m_prev + 1) % 16, 0);
      else if (sel < 82) step(0, 1, 0, 1);
      else step(0, 1, $urandom_range(15), $urandom_range(3) == 0);
    end
    @(negedge clk);
    en = 0; reset = 0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, wanted 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
